// File: rtl/z85_insn_encoder.sv
// Serialises a Z80 instruction descriptor into its opcode byte stream.
// Emits one byte per accepted sink cycle, with prefix, displacement and immediate placement.
module z85_insn_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_grp,
  input  logic [1:0]       in_idx,
  input  logic [7:0]       in_op,
  input  logic [7:0]       in_disp,
  input  logic [15:0]      in_imm,
  input  logic [1:0]       in_imm_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_first,
  output logic             out_last,
  output logic             err,
  output logic [CNT_W-1:0] insn_count
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_IDX       = 3'd1,
    ST_GRP       = 3'd2,
    ST_DISP_PRE  = 3'd3,
    ST_OPC       = 3'd4,
    ST_DISP_POST = 3'd5,
    ST_IMM_LO    = 3'd6,
    ST_IMM_HI    = 3'd7
  } state_t;

  // Indexed BASE opcodes that reference (IX+d)/(IY+d) and so carry a displacement.
  function automatic logic need_disp(input logic [7:0] op);
    logic r;
    case (op[7:6])
      2'd1:    r = ((op[5:3] == 3'd6) || (op[2:0] == 3'd6)) && (op != 8'h76);
      2'd0:    r = (op[5:3] == 3'd6) && ((op[2:0] == 3'd4) || (op[2:0] == 3'd5) || (op[2:0] == 3'd6));
      2'd2:    r = (op[2:0] == 3'd6);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic stage_en(input state_t s, input logic [1:0] g, input logic [1:0] i,
                                    input logic [7:0] op, input logic [1:0] len);
    logic r;
    case (s)
      ST_IDX:       r = (i != 2'd0);
      ST_GRP:       r = (g != 2'd0);
      ST_DISP_PRE:  r = (g == 2'd3);
      ST_OPC:       r = 1'b1;
      ST_DISP_POST: r = (g == 2'd0) && (i != 2'd0) && need_disp(op);
      ST_IMM_LO:    r = ((g == 2'd0) || (g == 2'd2)) && (len != 2'd0);
      ST_IMM_HI:    r = ((g == 2'd0) || (g == 2'd2)) && (len == 2'd2);
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

  // First enabled stage strictly after s; IDLE when the instruction is exhausted.
  function automatic state_t next_stage(input state_t s, input logic [1:0] g, input logic [1:0] i,
                                        input logic [7:0] op, input logic [1:0] len);
    state_t r;
    state_t cand;
    r = ST_IDLE;
    for (int k = 7; k >= 1; k--) begin
      cand = state_t'(k[2:0]);
      if ((k > int'(s)) && stage_en(cand, g, i, op, len)) begin
        r = cand;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] stage_byte(input state_t s, input logic [1:0] g, input logic [1:0] i,
                                            input logic [7:0] op, input logic [7:0] d,
                                            input logic [15:0] imm);
    logic [7:0] r;
    case (s)
      ST_IDX:       r = (i == 2'd1) ? 8'hDD : 8'hFD;
      ST_GRP:       r = (g == 2'd2) ? 8'hED : 8'hCB;
      ST_DISP_PRE:  r = d;
      ST_OPC:       r = op;
      ST_DISP_POST: r = d;
      ST_IMM_LO:    r = imm[7:0];
      ST_IMM_HI:    r = imm[15:8];
      default:      r = 8'h00;
    endcase
    return r;
  endfunction

  state_t           state_r;
  logic [1:0]       grp_r;
  logic [1:0]       idx_r;
  logic [7:0]       op_r;
  logic [7:0]       disp_r;
  logic [15:0]      imm_r;
  logic [1:0]       len_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [7:0]       out_byte_r;
  logic             out_first_r;
  logic             out_last_r;
  logic             err_r;
  logic [CNT_W-1:0] count_r;

  logic             accept_s;
  logic             xfer_s;
  logic             reject_s;
  logic [1:0]       norm_grp_s;
  logic [1:0]       g_s;
  logic [1:0]       i_s;
  logic [7:0]       op_s;
  logic [7:0]       d_s;
  logic [15:0]      imm_s;
  logic [1:0]       len_s;
  state_t           state_nx_s;
  logic             valid_nx_s;
  logic [7:0]       byte_nx_s;
  logic             first_nx_s;
  logic             last_nx_s;
  logic             err_nx_s;
  logic             count_inc_s;

  // Next-state and next-output computation; fields come straight from the inputs on acceptance.
  always_comb begin
    accept_s   = in_valid & in_ready_r;
    xfer_s     = out_valid_r & out_ready;
    norm_grp_s = ((in_grp == 2'd1) && (in_idx != 2'd0)) ? 2'd3 : in_grp;
    reject_s   = (in_idx == 2'd3) || (in_imm_len == 2'd3) ||
                 ((in_grp == 2'd3) && (in_idx == 2'd0)) ||
                 ((in_grp == 2'd2) && (in_idx != 2'd0));
    if (accept_s) begin
      g_s = norm_grp_s; i_s = in_idx; op_s = in_op; d_s = in_disp; imm_s = in_imm; len_s = in_imm_len;
    end else begin
      g_s = grp_r; i_s = idx_r; op_s = op_r; d_s = disp_r; imm_s = imm_r; len_s = len_r;
    end
    state_nx_s  = state_r;
    valid_nx_s  = out_valid_r;
    byte_nx_s   = out_byte_r;
    first_nx_s  = out_first_r;
    last_nx_s   = out_last_r;
    err_nx_s    = 1'b0;
    count_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !reject_s) begin
          state_nx_s = next_stage(ST_IDLE, g_s, i_s, op_s, len_s);
          valid_nx_s = 1'b1;
          byte_nx_s  = stage_byte(state_nx_s, g_s, i_s, op_s, d_s, imm_s);
          first_nx_s = 1'b1;
          last_nx_s  = (next_stage(state_nx_s, g_s, i_s, op_s, len_s) == ST_IDLE);
        end else if (accept_s) begin
          err_nx_s = 1'b1;
        end else begin
          valid_nx_s = 1'b0;
        end
      end
      default: begin
        if (xfer_s && out_last_r) begin
          state_nx_s  = ST_IDLE;
          valid_nx_s  = 1'b0;
          first_nx_s  = 1'b0;
          last_nx_s   = 1'b0;
          count_inc_s = 1'b1;
        end else if (xfer_s) begin
          state_nx_s = next_stage(state_r, g_s, i_s, op_s, len_s);
          byte_nx_s  = stage_byte(state_nx_s, g_s, i_s, op_s, d_s, imm_s);
          first_nx_s = 1'b0;
          last_nx_s  = (next_stage(state_nx_s, g_s, i_s, op_s, len_s) == ST_IDLE);
        end else begin
          state_nx_s = state_r;
        end
      end
    endcase
  end

  // State, latched descriptor and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      grp_r       <= 2'd0;
      idx_r       <= 2'd0;
      op_r        <= 8'h00;
      disp_r      <= 8'h00;
      imm_r       <= 16'h0000;
      len_r       <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_byte_r  <= 8'h00;
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
      err_r       <= 1'b0;
      count_r     <= '0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == ST_IDLE);
      out_valid_r <= valid_nx_s;
      out_byte_r  <= byte_nx_s;
      out_first_r <= first_nx_s;
      out_last_r  <= last_nx_s;
      err_r       <= err_nx_s;
      if (accept_s) begin
        grp_r  <= norm_grp_s;
        idx_r  <= in_idx;
        op_r   <= in_op;
        disp_r <= in_disp;
        imm_r  <= in_imm;
        len_r  <= in_imm_len;
      end
      if (count_inc_s) begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_byte   = out_byte_r;
  assign out_first  = out_first_r;
  assign out_last   = out_last_r;
  assign err        = err_r;
  assign insn_count = count_r;

endmodule

// File: tb/tb_z85_insn_encoder.sv
// Directed bench for z85_insn_encoder: a byte-list model builds each expected
// stream and a negedge monitor checks every transferred byte against it.
module tb_z85_insn_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_grp = 2'd0;
  logic [1:0]  in_idx = 2'd0;
  logic [7:0]  in_op = 8'h00;
  logic [7:0]  in_disp = 8'h00;
  logic [15:0] in_imm = 16'h0000;
  logic [1:0]  in_imm_len = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_byte;
  logic        out_first;
  logic        out_last;
  logic        err;
  logic [15:0] insn_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  logic [7:0] mq[$];
  logic [9:0] eq[$];

  z85_insn_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_grp(in_grp), .in_idx(in_idx), .in_op(in_op), .in_disp(in_disp),
    .in_imm(in_imm), .in_imm_len(in_imm_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_byte(out_byte), .out_first(out_first),
    .out_last(out_last), .err(err), .insn_count(insn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit ix_mem(input logic [7:0] op);
    logic [1:0] x; logic [2:0] y; logic [2:0] z;
    x = op[7:6]; y = op[5:3]; z = op[2:0];
    if (op == 8'h76) return 1'b0;
    if (x == 2'd1) return (y == 3'd6) || (z == 3'd6);
    if (x == 2'd0) return (y == 3'd6) && (z >= 3'd4) && (z <= 3'd6);
    if (x == 2'd2) return (z == 3'd6);
    return 1'b0;
  endfunction

  // Builds the expected byte list in mq straight from the encoding rules.
  task automatic build(input logic [1:0] grp, input logic [1:0] idx, input logic [7:0] op,
                       input logic [7:0] d, input logic [15:0] imm, input logic [1:0] len,
                       output bit bad);
    logic [1:0] g; logic [7:0] pfx;
    mq.delete();
    bad = (idx == 2'd3) || (len == 2'd3) || (grp == 2'd3 && idx == 2'd0) || (grp == 2'd2 && idx != 2'd0);
    if (!bad) begin
      g = (grp == 2'd1 && idx != 2'd0) ? 2'd3 : grp;
      pfx = (idx == 2'd1) ? 8'hDD : 8'hFD;
      case (g)
        2'd0: begin
          if (idx != 2'd0) mq.push_back(pfx);
          mq.push_back(op);
          if (idx != 2'd0 && ix_mem(op)) mq.push_back(d);
        end
        2'd1: begin mq.push_back(8'hCB); mq.push_back(op); end
        2'd2: begin mq.push_back(8'hED); mq.push_back(op); end
        default: begin mq.push_back(pfx); mq.push_back(8'hCB); mq.push_back(d); mq.push_back(op); end
      endcase
      if (g == 2'd0 || g == 2'd2) begin
        if (len >= 2'd1) mq.push_back(imm[7:0]);
        if (len == 2'd2) mq.push_back(imm[15:8]);
      end
    end
  endtask

  function automatic logic [39:0] packed_mq();
    logic [39:0] v = 40'h0;
    foreach (mq[k]) v = (v << 8) | 40'(mq[k]);
    return v;
  endfunction

  task automatic pin(input string name, input logic [1:0] grp, input logic [1:0] idx, input logic [7:0] op,
                     input logic [7:0] d, input logic [15:0] imm, input logic [1:0] len,
                     input logic [39:0] exp_bytes, input int exp_n);
    bit bad;
    build(grp, idx, op, d, imm, len, bad);
    chk({name, "_bytes"}, packed_mq(), exp_bytes);
    chk({name, "_len"}, mq.size(), exp_n);
  endtask

  // mode 0: free-running sink, 1: three-cycle stall after byte 1, 2: reset after byte 2
  task automatic send(input logic [1:0] grp, input logic [1:0] idx, input logic [7:0] op,
                      input logic [7:0] d, input logic [15:0] imm, input logic [1:0] len, input int mode);
    bit bad; bit aborted; int n; int cyc; int budget;
    build(grp, idx, op, d, imm, len, bad);
    n = mq.size();
    budget = 0;
    while (!in_ready && budget < 50) begin @(posedge clk); #1; budget++; end
    chk("in_ready_idle", in_ready, 1);
    foreach (mq[k]) eq.push_back({(k == 0) ? 1'b1 : 1'b0, (k == n - 1) ? 1'b1 : 1'b0, mq[k]});
    in_valid = 1'b1; in_grp = grp; in_idx = idx; in_op = op; in_disp = d; in_imm = imm; in_imm_len = len;
    @(posedge clk); #1;
    in_valid = 1'b0; in_grp = 2'd3; in_idx = 2'd3; in_op = 8'hA5; in_disp = 8'h5A; in_imm = 16'hDEAD; in_imm_len = 2'd3;
    chk("err_after_accept", err, bad);
    chk("valid_after_accept", out_valid, !bad);
    cyc = 0; aborted = 1'b0;
    while (!in_ready && cyc < 40 && !aborted) begin
      if (mode == 1 && cyc == 1) out_ready = 1'b0;
      if (mode == 1 && cyc == 4) out_ready = 1'b1;
      if (mode == 2 && cyc == 2) begin
        rst = 1'b1; #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", insn_count, 0);
        eq.delete(); exp_count = 0; aborted = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
    if (!aborted) begin
      chk("cycles", cyc, n + ((mode == 1) ? 3 : 0));
      if (!bad) exp_count++;
      chk("insn_count", insn_count, exp_count);
      chk("queue_drained", eq.size(), 0);
      if (bad) begin
        @(posedge clk); #1;
        chk("err_one_cycle", err, 0);
        chk("no_valid_on_reject", out_valid, 0);
      end
    end
  endtask

  logic       prev_stall = 1'b0;
  logic [9:0] prev_out = 10'h0;
  logic [9:0] got;
  logic [9:0] want;

  // Every cycle: in_ready excluded while busy, stall stability, byte-by-byte scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      got = {out_first, out_last, out_byte};
      if (out_valid) chk("in_ready_busy", in_ready, 0);
      if (prev_stall) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_stable", got, prev_out);
      end
      if (out_valid && out_ready) begin
        if (eq.size() == 0) begin
          chk("unexpected_byte", got, 10'h3FF);
        end else begin
          want = eq.pop_front();
          chk("stream_byte", got, want);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out = got;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    pin("pin_dd36", 2'd0, 2'd1, 8'h36, 8'hFE, 16'h0055, 2'd1, 40'hDD36FE55, 4);
    pin("pin_fdcb", 2'd1, 2'd2, 8'hC6, 8'h05, 16'h1234, 2'd2, 40'hFDCB05C6, 4);
    pin("pin_ed43", 2'd2, 2'd0, 8'h43, 8'h00, 16'hBEEF, 2'd2, 40'hED43EFBE, 4);
    pin("pin_dd76", 2'd0, 2'd1, 8'h76, 8'h10, 16'h0000, 2'd0, 40'h000000DD76, 2);
    pin("pin_dd21", 2'd0, 2'd1, 8'h21, 8'h77, 16'h1234, 2'd2, 40'h00DD213412, 4);

    repeat (2) @(posedge clk); #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_byte", out_byte, 0);
    chk("reset_flags", {out_first, out_last, err}, 0);
    chk("reset_count", insn_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(2'd0, 2'd0, 8'h3E, 8'h00, 16'h0042, 2'd1, 0);
    send(2'd0, 2'd1, 8'h36, 8'hFE, 16'h0055, 2'd1, 0);
    send(2'd0, 2'd1, 8'h21, 8'h00, 16'h1234, 2'd2, 0);
    send(2'd1, 2'd2, 8'hC6, 8'h05, 16'h0000, 2'd0, 0);
    send(2'd2, 2'd0, 8'h43, 8'h00, 16'hBEEF, 2'd2, 0);
    send(2'd0, 2'd1, 8'h36, 8'hFE, 16'h0055, 2'd1, 1);
    send(2'd3, 2'd0, 8'h06, 8'h01, 16'h0000, 2'd0, 0);
    send(2'd2, 2'd1, 8'h43, 8'h00, 16'h0000, 2'd0, 0);
    send(2'd0, 2'd0, 8'h3E, 8'h00, 16'h0042, 2'd3, 0);
    send(2'd0, 2'd3, 8'h3E, 8'h00, 16'h0042, 2'd1, 0);
    send(2'd0, 2'd1, 8'h76, 8'h10, 16'h0000, 2'd0, 0);
    send(2'd3, 2'd1, 8'h06, 8'h80, 16'hFFFF, 2'd2, 0);
    send(2'd1, 2'd0, 8'h11, 8'h33, 16'h4444, 2'd2, 0);
    send(2'd0, 2'd0, 8'h00, 8'h00, 16'h0000, 2'd0, 0);
    send(2'd0, 2'd2, 8'h34, 8'h7F, 16'h0000, 2'd0, 0);
    send(2'd0, 2'd1, 8'h86, 8'h81, 16'h0000, 2'd0, 0);
    send(2'd0, 2'd2, 8'h70, 8'h02, 16'h9999, 2'd1, 0);
    send(2'd0, 2'd1, 8'h21, 8'h00, 16'h1234, 2'd2, 2);
    send(2'd0, 2'd0, 8'h3E, 8'h00, 16'h0042, 2'd1, 0);

    repeat (2) @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
